// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int W = 32;
  localparam int N = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_AUX  = 1'b1;

  typedef struct packed {
    logic         we;
    logic [N-1:0] addr;
    logic [W-1:0] wdata;
    logic         port;
  } req_t;

endpackage

// File: rtl/dmem_arb_grant.sv
// Combinational two-way grant. With DMEM_ARB_RR_EN defined, the port named by
// prio wins a contended cycle; otherwise port 0 always wins.
module dmem_arb_grant
  import dmem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       prio,
  output logic       gnt_any,
  output logic       gnt_port
);

`ifndef DMEM_ARB_RR_EN
  // Fixed priority ignores the pointer input.
  logic unused_prio;
  assign unused_prio = prio;
`endif

  // Pick the winning port among the valid requesters.
  always_comb begin
    gnt_any  = |valid;
    gnt_port = PORT_CORE;
`ifdef DMEM_ARB_RR_EN
    if (valid == 2'b11) begin
      gnt_port = prio;
    end else if (valid[1]) begin
      gnt_port = PORT_AUX;
    end
`else
    if (!valid[0] && valid[1]) begin
      gnt_port = PORT_AUX;
    end
`endif
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer in front of data_memory. Each accepted request
// runs IDLE -> ACCESS -> RESP. Optional round-robin build: DMEM_ARB_RR_EN.
module dmem_arbiter #(
  parameter int W = 32,
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         p0_valid,
  input  logic         p0_we,
  input  logic [N-1:0] p0_addr,
  input  logic [W-1:0] p0_wdata,
  output logic         p0_ready,
  output logic         p0_resp_valid,
  output logic [W-1:0] p0_rdata,
  input  logic         p1_valid,
  input  logic         p1_we,
  input  logic [N-1:0] p1_addr,
  input  logic [W-1:0] p1_wdata,
  output logic         p1_ready,
  output logic         p1_resp_valid,
  output logic [W-1:0] p1_rdata,
  output logic         MemRead,
  output logic         MemWrite,
  output logic [N-1:0] address,
  output logic [W-1:0] write_data,
  input  logic [W-1:0] read_data
);
  import dmem_arb_pkg::*;

  state_e       state_q, state_d;
  logic         we_q, we_d;
  logic [N-1:0] addr_q, addr_d;
  logic [W-1:0] wdata_q, wdata_d;
  logic         port_q, port_d;
  logic [W-1:0] rdata0_q, rdata0_d;
  logic [W-1:0] rdata1_q, rdata1_d;
  logic         gnt_any, gnt_port, grant_fire, prio;

  // Ready is suppressed while rst is high so nothing is accepted during reset.
  assign grant_fire = (state_q == IDLE) && gnt_any && !rst;

  dmem_arb_grant u_grant (
    .valid    ({p1_valid, p0_valid}),
    .prio     (prio),
    .gnt_any  (gnt_any),
    .gnt_port (gnt_port)
  );

`ifdef DMEM_ARB_RR_EN
  logic prio_q, prio_d;
  assign prio = prio_q;

  // The port just granted drops to lowest priority; the pointer moves only on a grant.
  always_comb begin
    prio_d = prio_q;
    if (grant_fire) begin
      prio_d = ~gnt_port;
    end
  end

  // Round-robin pointer register; port 0 is favoured out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= PORT_CORE;
    end else begin
      prio_q <= prio_d;
    end
  end
`else
  assign prio = PORT_CORE;
`endif

  // Next-state, request latch, response capture and memory-side drive.
  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    port_d        = port_q;
    rdata0_d      = rdata0_q;
    rdata1_d      = rdata1_q;
    p0_ready      = 1'b0;
    p1_ready      = 1'b0;
    p0_resp_valid = 1'b0;
    p1_resp_valid = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    address       = '0;
    write_data    = '0;
    case (state_q)
      IDLE: begin
        if (grant_fire) begin
          state_d = ACCESS;
          port_d  = gnt_port;
          if (gnt_port == PORT_AUX) begin
            p1_ready = 1'b1;
            we_d     = p1_we;
            addr_d   = p1_addr;
            wdata_d  = p1_wdata;
          end else begin
            p0_ready = 1'b1;
            we_d     = p0_we;
            addr_d   = p0_addr;
            wdata_d  = p0_wdata;
          end
        end
      end
      ACCESS: begin
        address    = addr_q;
        write_data = wdata_q;
        MemWrite   = we_q;
        MemRead    = !we_q;
        if (!we_q) begin
          if (port_q == PORT_AUX) begin
            rdata1_d = read_data;
          end else begin
            rdata0_d = read_data;
          end
        end
        state_d = RESP;
      end
      RESP: begin
        p0_resp_valid = (port_q == PORT_CORE);
        p1_resp_valid = (port_q == PORT_AUX);
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and response data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Request latch; only meaningful after a grant, so it carries no reset.
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    port_q  <= port_d;
  end

  assign p0_rdata = rdata0_q;
  assign p1_rdata = rdata1_q;

endmodule
